// File: rtl/dlf_gearshift_if.sv
`default_nettype none
// ============================================================================
// Module      : dlf_gearshift_if
// Description : Sample, control, coefficient-write and result signals of the
//               gear-shifting digital loop filter. The master modport drives
//               samples and controls; the slave modport is the filter itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface dlf_gearshift_if #(
  parameter int IO_W   = 8,
  parameter int COEF_W = 20
);

  // Sample path and loop controls
  logic [IO_W-1:0]   master_in;
  logic              lead;
  logic              in_valid;
  logic              freeze;
  logic              auto_gear;
  logic              gear_manual;

  // Coefficient write port
  logic              coef_we;
  logic              coef_bank;
  logic [2:0]        coef_sel;
  logic [COEF_W-1:0] coef_wdata;

  // Results and status
  logic [IO_W-1:0]   slave_out;
  logic              out_valid;
  logic              sat;
  logic              gear;
  logic              locked;

  modport master (
    output master_in, lead, in_valid, freeze, auto_gear, gear_manual,
    output coef_we, coef_bank, coef_sel, coef_wdata,
    input  slave_out, out_valid, sat, gear, locked
  );

  modport slave (
    input  master_in, lead, in_valid, freeze, auto_gear, gear_manual,
    input  coef_we, coef_bank, coef_sel, coef_wdata,
    output slave_out, out_valid, sat, gear, locked
  );

endinterface
`default_nettype wire

// File: rtl/dlf_gearshift.sv
`default_nettype none
// ============================================================================
// Module      : dlf_gearshift
// Description : Third-order IIR loop filter for a digital PLL with two
//               coefficient banks. An acquisition/tracking lock detector can
//               select the bank automatically (gear shifting), or the bank is
//               chosen manually. Output is a saturated signed DCO word.
// Revision    : 1.0 - initial release
// ============================================================================
module dlf_gearshift #(
  parameter int IO_W       = 8,
  parameter int COEF_INT   = 2,
  parameter int COEF_FRAC  = 18,
  parameter int LOCK_THR   = 2,
  parameter int UNLOCK_THR = 8,
  parameter int LOCK_LEN   = 64
) (
  input wire logic        clk,
  input wire logic        rstn,
  dlf_gearshift_if.slave  bus
);

  localparam int COEF_W = COEF_INT + COEF_FRAC;
  // Signed sample / delay-line width: magnitude plus sign
  localparam int X_W    = IO_W + 1;
  // Seven products of X_W x COEF_W bits summed without overflow
  localparam int ACC_W  = X_W + COEF_W + 3;
  // Width left after removing the fractional bits
  localparam int SC_W   = ACC_W - COEF_FRAC;
  localparam int CNT_W  = $clog2(LOCK_LEN + 1);
  localparam int NCOEF  = 7;

  // Coefficient slots: b0,b1,b2,b3,a1,a2,a3
  localparam int C_IDX_B0 = 0;
  localparam int C_IDX_B1 = 1;
  localparam int C_IDX_B2 = 2;
  localparam int C_IDX_B3 = 3;
  localparam int C_IDX_A1 = 4;
  localparam int C_IDX_A2 = 5;
  localparam int C_IDX_A3 = 6;

  // Lock detector states
  localparam logic [0:0] ST_ACQ = 1'b0;
  localparam logic [0:0] ST_TRK = 1'b1;

  // Clamp limits: feedback state keeps one extra bit of headroom
  localparam logic signed [SC_W-1:0] C_Y_MAX = SC_W'((2 ** IO_W) - 1);
  localparam logic signed [SC_W-1:0] C_Y_MIN = SC_W'(-(2 ** IO_W));
  localparam logic signed [SC_W-1:0] C_O_MAX = SC_W'((2 ** (IO_W - 1)) - 1);
  localparam logic signed [SC_W-1:0] C_O_MIN = SC_W'(-(2 ** (IO_W - 1)));

  // Power-up loop coefficients, round-to-nearest at 18 fractional bits
  function automatic logic signed [COEF_W-1:0] rst_coef(input int idx);
    int v;
    case (idx)
      C_IDX_B0: v = 2561;     //  0.0097690
      C_IDX_B1: v = 2660;     //  0.0101456
      C_IDX_B2: v = -2363;    // -0.0090159
      C_IDX_B3: v = -2462;    // -0.0093925
      C_IDX_A1: v = -430443;  // -1.64201
      C_IDX_A2: v = 184751;   //  0.70477
      C_IDX_A3: v = -16444;   // -0.06273
      default:  v = 0;
    endcase
    return COEF_W'(v);
  endfunction

  // Sign-extend both operands to accumulator width before multiplying so
  // the product is exact and every term adds at the same width.
  function automatic logic signed [ACC_W-1:0] mul_ext(
    input logic signed [X_W-1:0]    a,
    input logic signed [COEF_W-1:0] c
  );
    logic signed [ACC_W-1:0] ae;
    logic signed [ACC_W-1:0] ce;
    ae = ACC_W'(a);
    ce = ACC_W'(c);
    return ae * ce;
  endfunction

  logic                     accept;
  logic signed [X_W-1:0]    x_s;
  logic signed [X_W-1:0]    x1_q, x2_q, x3_q;
  logic signed [X_W-1:0]    y1_q, y2_q, y3_q;
  logic signed [COEF_W-1:0] coef_q [2][NCOEF];
  logic                     gear_man_q;
  logic                     gear_s;
  logic [0:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     fsm_gear;
  logic                     fsm_locked;
  logic signed [ACC_W-1:0]  acc;
  logic signed [SC_W-1:0]   sc;
  logic signed [SC_W-1:0]   y_clip;
  logic signed [SC_W-1:0]   o_clip;
  logic                     o_clipped;
  logic [IO_W-1:0]          slave_out_q;
  logic                     out_valid_q;
  logic                     sat_q;

  // A sample is consumed only when strobed and not frozen
  assign accept = bus.in_valid & ~bus.freeze;

  // Signed phase error; negating a zero magnitude still gives zero
  assign x_s = bus.lead ?  $signed({1'b0, bus.master_in})
                        : -$signed({1'b0, bus.master_in});

  // Bank in use: lock detector when automatic, registered manual select otherwise
  assign gear_s = bus.auto_gear ? fsm_gear : gear_man_q;

  // Full-precision difference equation on the active bank
  always_comb begin
    acc = mul_ext(x_s,  coef_q[gear_s][C_IDX_B0])
        + mul_ext(x1_q, coef_q[gear_s][C_IDX_B1])
        + mul_ext(x2_q, coef_q[gear_s][C_IDX_B2])
        + mul_ext(x3_q, coef_q[gear_s][C_IDX_B3])
        - mul_ext(y1_q, coef_q[gear_s][C_IDX_A1])
        - mul_ext(y2_q, coef_q[gear_s][C_IDX_A2])
        - mul_ext(y3_q, coef_q[gear_s][C_IDX_A3]);
  end

  // Arithmetic shift floors toward -inf; dropped top bits are sign copies
  assign sc = SC_W'(acc >>> COEF_FRAC);

  // Clamp the scaled result for the feedback state and for the output word
  always_comb begin
    y_clip    = sc;
    o_clip    = sc;
    o_clipped = 1'b0;
    if (sc > C_Y_MAX) begin
      y_clip = C_Y_MAX;
    end else if (sc < C_Y_MIN) begin
      y_clip = C_Y_MIN;
    end
    if (sc > C_O_MAX) begin
      o_clip    = C_O_MAX;
      o_clipped = 1'b1;
    end else if (sc < C_O_MIN) begin
      o_clip    = C_O_MIN;
      o_clipped = 1'b1;
    end
  end

  // Delay lines and output register advance only on accepted samples
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x1_q        <= '0;
      x2_q        <= '0;
      x3_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      y3_q        <= '0;
      slave_out_q <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      out_valid_q <= accept;
      sat_q       <= accept & o_clipped;
      if (accept) begin
        x1_q        <= x_s;
        x2_q        <= x1_q;
        x3_q        <= x2_q;
        y1_q        <= X_W'(y_clip);
        y2_q        <= y1_q;
        y3_q        <= y2_q;
        slave_out_q <= IO_W'(o_clip);
      end
    end
  end

  // Coefficient banks; a same-edge sample still reads the old value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NCOEF; k++) begin
          coef_q[b][k] <= rst_coef(k);
        end
      end
    end else if (bus.coef_we && (bus.coef_sel != 3'd7)) begin
      coef_q[bus.coef_bank][bus.coef_sel] <= bus.coef_wdata;
    end
  end

  // Manual bank select is registered once before use
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gear_man_q <= 1'b0;
    end else begin
      gear_man_q <= bus.gear_manual;
    end
  end

  // Lock detector state and run-length counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_ACQ;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lock detector transitions, evaluated on accepted samples only
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      case (state_q)
        ST_ACQ: begin
          if (bus.master_in <= IO_W'(LOCK_THR)) begin
            if (cnt_q == CNT_W'(LOCK_LEN - 1)) begin
              state_d = ST_TRK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_TRK: begin
          if (bus.master_in > IO_W'(UNLOCK_THR)) begin
            state_d = ST_ACQ;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_ACQ;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Lock detector outputs: tracking means locked and the tracking bank
  always_comb begin
    fsm_gear   = 1'b0;
    fsm_locked = 1'b0;
    if (state_q == ST_TRK) begin
      fsm_gear   = 1'b1;
      fsm_locked = 1'b1;
    end
  end

  assign bus.slave_out = slave_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat       = sat_q;
  assign bus.gear      = gear_s;
  assign bus.locked    = fsm_locked;

endmodule
`default_nettype wire

// File: tb/tb_dlf_gearshift.sv
`default_nettype none
// ============================================================================
// Module      : tb_dlf_gearshift
// Description : Directed self-checking bench for dlf_gearshift with a small
//               integer reference model of the loop filter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dlf_gearshift;

  localparam int IO_W   = 8;
  localparam int COEF_W = 20;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  dlf_gearshift_if #(.IO_W(IO_W), .COEF_W(COEF_W)) bus_if ();

  dlf_gearshift #(.IO_W(IO_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state: coefficient mirror, delay lines, active bank
  longint mb [2][7];
  longint mx [3];
  longint my [3];
  bit     mgear;
  int     m_out;

  task automatic check_val(input string tag, input logic signed [31:0] act,
                           input logic signed [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      mb[b][0] = 2561;    mb[b][1] = 2660;    mb[b][2] = -2363; mb[b][3] = -2462;
      mb[b][4] = -430443; mb[b][5] = 184751;  mb[b][6] = -16444;
    end
    for (int i = 0; i < 3; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
    m_out = 0;
  endtask

  // One accepted sample: floor division by 2^18, two clamp ranges
  task automatic model_step(input int x, output int o, output bit s);
    longint acc;
    longint q;
    int     g;
    g   = int'(mgear);
    acc = mb[g][0] * x + mb[g][1] * mx[0] + mb[g][2] * mx[1] + mb[g][3] * mx[2]
        - mb[g][4] * my[0] - mb[g][5] * my[1] - mb[g][6] * my[2];
    q = acc / 262144;
    if (acc < 0 && q * 262144 != acc) q = q - 1;
    o = int'(clampl(q, -128, 127));
    s = (longint'(o) != q);
    my[2] = my[1]; my[1] = my[0]; my[0] = clampl(q, -256, 255);
    mx[2] = mx[1]; mx[1] = mx[0]; mx[0] = x;
    m_out = o;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.freeze    = 1'b0;
    bus_if.coef_we   = 1'b0;
    bus_if.master_in = '0;
    bus_if.lead      = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Drive one strobe, then check the result one cycle later
  task automatic send(input int m, input bit ld, input bit do_chk, input string tag);
    int oe;
    bit se;
    int xe;
    @(negedge clk);
    if (do_chk) check_val({tag, ".idle"}, bus_if.out_valid, 0);
    bus_if.master_in = m[7:0];
    bus_if.lead      = ld;
    bus_if.in_valid  = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    xe = ld ? m : -m;
    model_step(xe, oe, se);
    if (do_chk) begin
      check_val({tag, ".ov"},  bus_if.out_valid, 1);
      check_val({tag, ".out"}, $signed(bus_if.slave_out), oe);
      check_val({tag, ".sat"}, bus_if.sat, se);
    end
  endtask

  // Strobe while frozen: nothing may move
  task automatic hold_cycles(input int n, input int m, input string tag);
    @(negedge clk);
    bus_if.freeze    = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.master_in = m[7:0];
    bus_if.lead      = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val({tag, ".ov"},  bus_if.out_valid, 0);
      check_val({tag, ".out"}, $signed(bus_if.slave_out), m_out);
    end
    bus_if.freeze   = 1'b0;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic write_coef(input int bank, input int sel, input int val);
    @(negedge clk);
    bus_if.coef_we    = 1'b1;
    bus_if.coef_bank  = bank[0];
    bus_if.coef_sel   = sel[2:0];
    bus_if.coef_wdata = val[19:0];
    @(negedge clk);
    bus_if.coef_we = 1'b0;
    if (sel != 7) mb[bank][sel] = val;
  endtask

  initial begin
    int oe;
    bit se;
    rstn = 1'b1;
    bus_if.master_in   = '0;
    bus_if.lead        = 1'b0;
    bus_if.in_valid    = 1'b0;
    bus_if.freeze      = 1'b0;
    bus_if.auto_gear   = 1'b0;
    bus_if.gear_manual = 1'b0;
    bus_if.coef_we     = 1'b0;
    bus_if.coef_bank   = 1'b0;
    bus_if.coef_sel    = '0;
    bus_if.coef_wdata  = '0;
    mgear = 1'b0;
    model_reset();

    // Asynchronous reset values, before any clock edge
    #2 rstn = 1'b0;
    #1;
    check_val("rst.out",    $signed(bus_if.slave_out), 0);
    check_val("rst.ov",     bus_if.out_valid, 0);
    check_val("rst.sat",    bus_if.sat, 0);
    check_val("rst.gear",   bus_if.gear, 0);
    check_val("rst.locked", bus_if.locked, 0);

    // Impulse of 100 then zeros on bank 0, manual gear
    do_reset();
    check_val("imp.pre_ov", bus_if.out_valid, 0);
    send(100, 1, 1, "imp0"); check_val("imp0.hand", $signed(bus_if.slave_out), 0);
    send(0, 0, 1, "imp1");   check_val("imp1.hand", $signed(bus_if.slave_out), 1);
    send(0, 1, 1, "imp2");   check_val("imp2.hand", $signed(bus_if.slave_out), 0);
    send(0, 0, 1, "imp3");   check_val("imp3.hand", $signed(bus_if.slave_out), -2);
    for (int i = 0; i < 4; i++) send(0, i[0], 1, "impa");
    hold_cycles(10, 50, "frz");
    for (int i = 0; i < 10; i++) send(0, i[0], 1, "impb");

    // Bank 1 b0 = 0.5 selected manually: x = 4 gives 2
    bus_if.gear_manual = 1'b1;
    mgear = 1'b1;
    do_reset();
    check_val("c39.gear", bus_if.gear, 1);
    write_coef(1, 0, 32'h20000);
    write_coef(1, 7, 32'h7FFFF);
    send(4, 1, 1, "c39");    check_val("c39.hand", $signed(bus_if.slave_out), 2);
    for (int i = 0; i < 5; i++) send(0, 1, 1, "c39z");

    // Write and sample on the same edge: sample sees the old b0
    do_reset();
    @(negedge clk);
    bus_if.coef_we    = 1'b1;
    bus_if.coef_bank  = 1'b1;
    bus_if.coef_sel   = 3'd0;
    bus_if.coef_wdata = 20'h20000;
    bus_if.master_in  = 8'd4;
    bus_if.lead       = 1'b1;
    bus_if.in_valid   = 1'b1;
    @(negedge clk);
    bus_if.coef_we  = 1'b0;
    bus_if.in_valid = 1'b0;
    model_step(4, oe, se);
    mb[1][0] = 131072;
    check_val("cw.ov",  bus_if.out_valid, 1);
    check_val("cw.old", $signed(bus_if.slave_out), 0);
    send(4, 1, 1, "cw1");    check_val("cw1.hand", $signed(bus_if.slave_out), 2);

    // Integrator on bank 1 (b0 = 0.25, a1 = -1): clip, no wrap
    do_reset();
    write_coef(1, 0, 65536);
    write_coef(1, 1, 0);
    write_coef(1, 2, 0);
    write_coef(1, 3, 0);
    write_coef(1, 4, -262144);
    write_coef(1, 5, 0);
    write_coef(1, 6, 0);
    send(255, 1, 1, "sp0");  check_val("sp0.hand", $signed(bus_if.slave_out), 63);
    send(255, 1, 1, "sp1");  check_val("sp1.hand", $signed(bus_if.slave_out), 126);
    for (int i = 0; i < 5; i++) send(255, 1, 1, "spx");
    check_val("sp.max", $signed(bus_if.slave_out), 127);
    check_val("sp.sat", bus_if.sat, 1);
    send(255, 0, 1, "sn0");  check_val("sn0.hand", $signed(bus_if.slave_out), 191 > 127 ? 127 : 0);
    send(255, 0, 1, "sn1");  check_val("sn1.hand", $signed(bus_if.slave_out), 127);
    for (int i = 0; i < 9; i++) send(255, 0, 1, "snx");
    check_val("sn.min", $signed(bus_if.slave_out), -128);
    check_val("sn.sat", bus_if.sat, 1);

    // Reset between strobe and result: everything clears, no late pulse
    @(negedge clk);
    bus_if.master_in = 8'd255;
    bus_if.lead      = 1'b0;
    bus_if.in_valid  = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check_val("mr.out",    $signed(bus_if.slave_out), 0);
    check_val("mr.ov",     bus_if.out_valid, 0);
    check_val("mr.sat",    bus_if.sat, 0);
    check_val("mr.gear",   bus_if.gear, 0);
    check_val("mr.locked", bus_if.locked, 0);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("mr.nopulse", bus_if.out_valid, 0);
    end

    // Automatic gear: lock after 64 quiet samples, freeze holds the count
    bus_if.auto_gear   = 1'b1;
    bus_if.gear_manual = 1'b0;
    mgear = 1'b0;
    do_reset();
    for (int i = 0; i < 40; i++) send(2, i[0], 0, "lk");
    send(3, 1, 0, "lk");
    for (int i = 0; i < 30; i++) send(1, i[0], 0, "lk");
    hold_cycles(10, 9, "lkfrz");
    for (int i = 0; i < 33; i++) send(1, i[0], 0, "lk");
    check_val("lk63.gear",   bus_if.gear, 0);
    check_val("lk63.locked", bus_if.locked, 0);
    send(1, 0, 0, "lk");
    check_val("lk64.gear",   bus_if.gear, 1);
    check_val("lk64.locked", bus_if.locked, 1);
    send(8, 1, 0, "lk");
    check_val("trk8.locked", bus_if.locked, 1);
    send(9, 0, 0, "lk");
    check_val("trk9.gear",   bus_if.gear, 0);
    check_val("trk9.locked", bus_if.locked, 0);

    // Lock detector keeps running with manual gear; value 2 counts as quiet
    bus_if.auto_gear = 1'b0;
    for (int i = 0; i < 64; i++) send(2, i[0], 0, "lkm");
    check_val("lkm.locked", bus_if.locked, 1);
    check_val("lkm.gear",   bus_if.gear, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dlf_gearshift.md
DLF_GEARSHIFT -- requirements
Module: dlf_gearshift

Interface
REQ-001 Parameter IO_W, default 8, magnitude width of master_in and width of slave_out.
REQ-002 Parameter COEF_INT, default 2; COEF_FRAC, default 18; COEF_W = COEF_INT+COEF_FRAC, signed Q2.18 coefficients.
REQ-003 Parameter LOCK_THR, default 2; UNLOCK_THR, default 8; LOCK_LEN, default 64 (accepted samples).
REQ-004 Port clk  in  1  single clock, all state on rising edge.
REQ-005 Port rstn  in  1  reset, asynchronous and active-low.
REQ-006 Port master_in  in  IO_W  unsigned phase-error magnitude.
REQ-007 Port lead  in  1  sign: 1 = feedback lead (positive), 0 = ref lead (negative).
REQ-008 Port in_valid  in  1  sample strobe.
REQ-009 Port freeze  in  1  hold loop state.
REQ-010 Port auto_gear  in  1  1 = lock-driven bank select, 0 = manual.
REQ-011 Port gear_manual  in  1  bank used when auto_gear=0.
REQ-012 Ports coef_we  in  1; coef_bank  in  1; coef_sel  in  3; coef_wdata  in  COEF_W  coefficient write port.
REQ-013 Port slave_out  out  IO_W  signed two's-complement DCO control word.
REQ-014 Ports out_valid  out  1; sat  out  1; gear  out  1; locked  out  1.

Function
REQ-015 Sample accepted iff in_valid=1 and freeze=0; x = +master_in if lead=1 else -master_in, IO_W+1 bits signed.
REQ-016 Per accepted sample: y = b0*x + b1*x1 + b2*x2 + b3*x3 - a1*y1 - a2*y2 - a3*y3, full precision (IO_W+1+COEF_W+3 bits), no intermediate overflow.
REQ-017 y scaled by arithmetic right shift of COEF_FRAC (truncation toward -inf).
REQ-018 Feedback state y1 gets scaled y saturated to IO_W+1 signed range; x1..x3 and y1..y3 shift only on accepted samples.
REQ-019 slave_out = scaled y saturated to [-2^(IO_W-1), 2^(IO_W-1)-1], registered; out_valid pulses 1 cycle, exactly one cycle after acceptance.
REQ-020 sat = 1 with the out_valid pulse when output saturation clipped; otherwise 0.
REQ-021 Not accepted cycle: all filter state and slave_out hold; out_valid=0.
REQ-022 Two coefficient banks of 7 registers; coef_sel 0..6 = b0,b1,b2,b3,a1,a2,a3; coef_sel=7 write ignored.
REQ-023 coef_we=1 writes coef_wdata to [coef_bank][coef_sel] at the clock edge; a sample accepted in the same cycle uses the old value.
REQ-024 Active bank = gear; auto_gear=0: gear follows gear_manual registered (1-cycle delay).
REQ-025 Auto lock FSM states ACQ (gear=0, locked=0) and TRK (gear=1, locked=1).
REQ-026 ACQ: lock counter +1 per accepted sample with |x|<=LOCK_THR, cleared by accepted |x|>LOCK_THR; at count LOCK_LEN move to TRK, counter clears.
REQ-027 TRK: accepted |x|>UNLOCK_THR returns to ACQ, counter cleared; |x|<=UNLOCK_THR stays.
REQ-028 Transition takes effect from the cycle after the triggering sample; the triggering sample uses the old bank.
REQ-029 Lock FSM runs regardless of auto_gear; locked always reflects FSM; gear taken from FSM only when auto_gear=1.
REQ-030 Bank switch does not clear delay lines.
REQ-031 master_in=0 with lead=0 yields x=0.

Reset
REQ-032 rstn=0 asynchronously clears delay lines, slave_out, out_valid, sat, lock counter; FSM to ACQ, gear=0, locked=0.
REQ-033 Both banks reset to b0=0.0097690, b1=0.0101456, b2=-0.0090159, b3=-0.0093925, a1=-1.64201, a2=0.70477, a3=-0.06273, Q2.18 rounded to nearest.
REQ-034 Reset mid-operation discards pending output; first out_valid after release only after a new accepted sample.

Verification
REQ-035 Post-reset: single accepted sample master_in=100, lead=1, then zeros -> slave_out sequence matches bit-exact reference model; first out_valid one cycle after strobe.
REQ-036 Constant master_in=255, lead=1 -> output reaches 127 with sat=1, no wrap to negative; lead=0 -> -128.
REQ-037 Auto gear: 64 accepted samples |x|=1 -> gear=1, locked=1 after the 64th; one sample |x|=9 -> gear=0 next cycle.
REQ-038 freeze=1 with in_valid=1 for 10 cycles -> slave_out, delay lines, lock counter unchanged; out_valid=0.
REQ-039 Write bank1 b0=0.5 (coef_wdata=0x20000) with auto_gear=0, gear_manual=1 -> impulse x=4 gives first output 2.
REQ-040 Assert rstn low between strobe and out_valid -> all outputs 0 immediately, no out_valid after release.
